fetch_unit: RTL and testbench

// - Instruction-fetch control for the 5-stage MIPS pipeline: owns the PC, drives the word address of the

---
 rtl/fetch_pkg.sv | 11 +
 rtl/pc_next_logic.sv | 34 +++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

   // Fetch FSM encoding
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

endpackage : fetch_pkg

// File: rtl/pc_next_logic.sv
// Combinational next-PC select: increment with wrap, redirect range check.
module pc_next_logic
   import fetch_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 128
) (
   input  logic [WORD_W-1:0] pc_i,
   input  logic [WORD_W-1:0] br_target_i,
   input  logic              halt_i,
   input  logic              pc_src_i,
   input  logic              stall_i,
   input  logic              zero_hit_i,
   output logic [WORD_W-1:0] pc_inc_c,
   output logic              br_ok_c,
   output logic [WORD_W-1:0] pc_next_c
);

   localparam logic [WORD_W-1:0] LAST_ADDR = WORD_W'(MEM_DEPTH - 1);
   localparam logic [WORD_W-1:0] DEPTH_W   = WORD_W'(MEM_DEPTH);

   assign pc_inc_c = (pc_i >= LAST_ADDR) ? '0 : pc_i + WORD_W'(1);
   assign br_ok_c  = (br_target_i < DEPTH_W);

   // In-range redirect wins everywhere; otherwise advance only on an ordinary RUN fetch
   always_comb begin
      pc_next_c = pc_i;
      if (pc_src_i && br_ok_c) begin
         pc_next_c = br_target_i;
      end else if (!halt_i && !pc_src_i && !stall_i && !zero_hit_i) begin
         pc_next_c = pc_inc_c;
      end
   end

endmodule : pc_next_logic

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives instruction-memory address, fills the IF/ID register.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned MEM_DEPTH    = 128,
   parameter int unsigned RESET_PC     = 0,
   parameter bit          HALT_ON_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   output logic [WORD_W-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_data,
   input  logic              stall,
   input  logic              pc_src,
   input  logic [WORD_W-1:0] br_target,
   output logic [WORD_W-1:0] if_id_instr,
   output logic [WORD_W-1:0] if_id_npc,
   output logic              if_id_valid,
   output logic              halted,
   output logic              fetch_err,
   output logic [WORD_W-1:0] fetch_count
);

   localparam logic [WORD_W-1:0] RESET_PC_W = WORD_W'(RESET_PC);

   logic [0:0]        state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic [WORD_W-1:0] npc_q, npc_d;
   logic              valid_q, valid_d;
   logic              halted_q, halted_d;
   logic              err_q, err_d;
   logic [WORD_W-1:0] count_q, count_d;

   logic [WORD_W-1:0] pc_inc_c;
   logic              br_ok_c;
   logic              zero_hit_c;

   assign zero_hit_c = HALT_ON_ZERO && (mem_data == NOP_WORD);

   pc_next_logic #(
      .MEM_DEPTH (MEM_DEPTH)
   ) u_pc_next (
      .pc_i        (pc_q),
      .br_target_i (br_target),
      .halt_i      (state_q == ST_HALT),
      .pc_src_i    (pc_src),
      .stall_i     (stall),
      .zero_hit_i  (zero_hit_c),
      .pc_inc_c    (pc_inc_c),
      .br_ok_c     (br_ok_c),
      .pc_next_c   (pc_d)
   );

   // Next-state and IF/ID update; priority redirect > bad redirect > stall > zero word > fetch
   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      npc_d    = npc_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      err_d    = err_q;
      count_d  = count_q;

      if (state_q == ST_HALT) begin
         valid_d = 1'b0;
         if (pc_src) begin
            if (br_ok_c) begin
               halted_d = 1'b0;
               state_d  = ST_RUN;
            end else begin
               err_d = 1'b1;
            end
         end
      end else begin
         if (pc_src) begin
            valid_d = 1'b0;
            if (!br_ok_c) begin
               err_d    = 1'b1;
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end
         end else if (!stall) begin
            if (zero_hit_c) begin
               valid_d  = 1'b0;
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end else begin
               instr_d = mem_data;
               npc_d   = pc_inc_c;
               valid_d = 1'b1;
               if (count_q != '1) begin
                  count_d = count_q + WORD_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= RESET_PC_W;
         instr_q  <= '0;
         npc_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         npc_q    <= npc_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         err_q    <= err_d;
         count_q  <= count_d;
      end
   end

   assign mem_addr    = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_npc   = npc_q;
   assign if_id_valid = valid_q;
   assign halted      = halted_q;
   assign fetch_err   = err_q;
   assign fetch_count = count_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed steps push expected snapshots, monitor compares.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        stall;
   logic        pc_src;
   logic [31:0] br_target;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_npc;
   logic        if_id_valid;
   logic        halted;
   logic        fetch_err;
   logic [31:0] fetch_count;

   logic [31:0] imem [128];

   typedef struct {
      int          cyc;
      int          id;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] npc;
      logic        valid;
      logic        halt;
      logic        err;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   cyc     = 0;
   int   step_id = 0;
   int   n_check = 0;
   int   n_fail  = 0;

   fetch_unit #(
      .MEM_DEPTH    (128),
      .RESET_PC     (0),
      .HALT_ON_ZERO (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .stall       (stall),
      .pc_src      (pc_src),
      .br_target   (br_target),
      .if_id_instr (if_id_instr),
      .if_id_npc   (if_id_npc),
      .if_id_valid (if_id_valid),
      .halted      (halted),
      .fetch_err   (fetch_err),
      .fetch_count (fetch_count)
   );

   assign mem_data = imem[mem_addr[6:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_check++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got %h expected %h", id, name, act, exp);
      end
   endtask

   // Monitor: compare the snapshot due on this cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.id, "mem_addr",    mem_addr,           e.addr);
         chk(e.id, "if_id_instr", if_id_instr,        e.instr);
         chk(e.id, "if_id_npc",   if_id_npc,          e.npc);
         chk(e.id, "if_id_valid", 32'(if_id_valid),   32'(e.valid));
         chk(e.id, "halted",      32'(halted),        32'(e.halt));
         chk(e.id, "fetch_err",   32'(fetch_err),     32'(e.err));
         chk(e.id, "fetch_count", fetch_count,        e.cnt);
      end
   end

   task automatic push_exp(input int at, input logic [31:0] ea, input logic [31:0] ei,
                           input logic [31:0] en, input logic ev, input logic eh,
                           input logic ee, input logic [31:0] ec);
      exp_t e;
      e.cyc = at; e.id = step_id; e.addr = ea; e.instr = ei; e.npc = en;
      e.valid = ev; e.halt = eh; e.err = ee; e.cnt = ec;
      exp_q.push_back(e);
      step_id++;
   endtask

   // Drive one cycle of inputs; expectation is the state after the following rising edge
   task automatic step(input logic r, input logic st, input logic ps, input logic [31:0] tgt,
                       input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] en,
                       input logic ev, input logic eh, input logic ee, input logic [31:0] ec);
      @(negedge clk);
      rst = r; stall = st; pc_src = ps; br_target = tgt;
      push_exp(cyc + 1, ea, ei, en, ev, eh, ee, ec);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) imem[i] = 32'h1000_0000 | 32'(i);
      imem[0]   = 32'h0023_00AA;
      imem[1]   = 32'h1065_4321;
      imem[2]   = 32'h0010_0022;
      imem[7]   = 32'hAC65_4321;
      imem[9]   = 32'h0000_0000;
      imem[127] = 32'hDEAD_007F;

      rst = 1'b0; stall = 1'b0; pc_src = 1'b0; br_target = '0;

      //   rst  st   ps   tgt    pc    instr          npc  v  h  e  cnt
      step(1'b0,1'b0,1'b0,32'd0, 32'd0,  32'h0,         32'd0,  0,0,0,32'd0);
      step(1'b1,1'b0,1'b0,32'd0, 32'd1,  32'h0023_00AA, 32'd1,  1,0,0,32'd1);
      step(1'b1,1'b0,1'b0,32'd0, 32'd2,  32'h1065_4321, 32'd2,  1,0,0,32'd2);
      step(1'b1,1'b1,1'b0,32'd0, 32'd2,  32'h1065_4321, 32'd2,  1,0,0,32'd2);
      step(1'b1,1'b1,1'b0,32'd0, 32'd2,  32'h1065_4321, 32'd2,  1,0,0,32'd2);
      step(1'b1,1'b0,1'b0,32'd0, 32'd3,  32'h0010_0022, 32'd3,  1,0,0,32'd3);
      // redirect with stall: bubble, pc to 7
      step(1'b1,1'b1,1'b1,32'd7, 32'd7,  32'h0010_0022, 32'd3,  0,0,0,32'd3);
      step(1'b1,1'b0,1'b0,32'd0, 32'd8,  32'hAC65_4321, 32'd8,  1,0,0,32'd4);
      step(1'b1,1'b0,1'b0,32'd0, 32'd9,  32'h1000_0008, 32'd9,  1,0,0,32'd5);
      // zero word at 9 halts
      step(1'b1,1'b0,1'b0,32'd0, 32'd9,  32'h1000_0008, 32'd9,  0,1,0,32'd5);
      step(1'b1,1'b0,1'b0,32'd0, 32'd9,  32'h1000_0008, 32'd9,  0,1,0,32'd5);
      step(1'b1,1'b0,1'b1,32'd0, 32'd0,  32'h1000_0008, 32'd9,  0,0,0,32'd5);
      step(1'b1,1'b0,1'b0,32'd0, 32'd1,  32'h0023_00AA, 32'd1,  1,0,0,32'd6);
      // redirect to the zero word, then redirect while it is presented: no halt
      step(1'b1,1'b0,1'b1,32'd9, 32'd9,  32'h0023_00AA, 32'd1,  0,0,0,32'd6);
      step(1'b1,1'b0,1'b1,32'd126,32'd126,32'h0023_00AA,32'd1,  0,0,0,32'd6);
      step(1'b1,1'b0,1'b0,32'd0, 32'd127,32'h1000_007E, 32'd127,1,0,0,32'd7);
      // wrap at the top of memory
      step(1'b1,1'b0,1'b0,32'd0, 32'd0,  32'hDEAD_007F, 32'd0,  1,0,0,32'd8);
      step(1'b1,1'b0,1'b1,32'd127,32'd127,32'hDEAD_007F,32'd0,  0,0,0,32'd8);
      // out-of-range redirect: error + halt, pc unchanged
      step(1'b1,1'b0,1'b1,32'd200,32'd127,32'hDEAD_007F,32'd0,  0,1,1,32'd8);
      step(1'b1,1'b0,1'b1,32'd128,32'd127,32'hDEAD_007F,32'd0,  0,1,1,32'd8);
      step(1'b1,1'b0,1'b1,32'd1, 32'd1,  32'hDEAD_007F, 32'd0,  0,0,1,32'd8);
      step(1'b1,1'b0,1'b0,32'd0, 32'd2,  32'h1065_4321, 32'd2,  1,0,1,32'd9);
      step(1'b1,1'b0,1'b0,32'd0, 32'd3,  32'h0010_0022, 32'd3,  1,0,1,32'd10);

      // asynchronous reset between edges must clear state before the next edge
      @(negedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;
      push_exp(cyc, 32'd0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b1,1'b0,1'b0,32'd0, 32'd1,  32'h0023_00AA, 32'd1,  1,0,0,32'd1);

      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_check++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
      $finish;
   end

endmodule : tb_fetch_unit
